// File: rtl/lpf_iir_mc_if.sv
// Sample-in / filtered-sample-out bus of the multi-channel IIR low-pass filter.
// The filter sits on the slave side; the sample source and sink use master.
interface lpf_iir_mc_if #(
  parameter int WIDTH = 10,
  parameter int CHW   = 2
);
  logic                    s_valid;
  logic                    s_ready;
  logic [CHW-1:0]          s_ch;
  logic signed [WIDTH-1:0] s_data;
  logic                    m_valid;
  logic [CHW-1:0]          m_ch;
  logic signed [WIDTH-1:0] m_data;

  modport master (output s_valid, s_ch, s_data, input s_ready, m_valid, m_ch, m_data);
  modport slave  (input s_valid, s_ch, s_data, output s_ready, m_valid, m_ch, m_data);
endinterface

// File: rtl/lpf_iir_mc.sv
// Time-multiplexed first-order IIR low-pass, y += alpha*(x - y), one shared multiplier
// for CH channels, three-stage pipeline with a same-channel stall instead of forwarding.
module lpf_iir_mc #(
  parameter int          WIDTH     = 10,
  parameter int          SCALE     = 15,
  parameter int          ALPHA_W   = 16,
  parameter int          CH        = 4,
  parameter int          CHW       = 2,
  parameter int unsigned ALPHA_RST = 12629
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               clr,
  input  logic               bypass,
  input  logic               alpha_we,
  input  logic [ALPHA_W-1:0] alpha_in,
  lpf_iir_mc_if.slave        bus
);
  localparam int PW = WIDTH + ALPHA_W + 1;
  localparam int SW = WIDTH + 2;
  localparam logic [ALPHA_W-1:0] ALPHA_ONE = {{(ALPHA_W-1){1'b0}}, 1'b1} << SCALE;
  localparam logic [PW-1:0]      RND_HALF  = {{(PW-1){1'b0}}, 1'b1} << (SCALE - 1);

  function automatic logic [ALPHA_W-1:0] clamp_alpha(input logic [ALPHA_W-1:0] a);
    if (a > ALPHA_ONE) return ALPHA_ONE;
    else return a;
  endfunction

  function automatic logic signed [WIDTH-1:0] sat_sum(input logic signed [SW-1:0] s);
    logic signed [SW-1:0] hi;
    logic signed [SW-1:0] lo;
    hi = SW'({1'b0, {(WIDTH-1){1'b1}}});
    lo = {{(SW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
    if (s > hi) return hi[WIDTH-1:0];
    else if (s < lo) return lo[WIDTH-1:0];
    else return s[WIDTH-1:0];
  endfunction

  logic [ALPHA_W-1:0]      alpha_r;
  logic signed [WIDTH-1:0] y_prev_r [CH];

  logic                    v1_r, byp1_r;
  logic [CHW-1:0]          ch1_r;
  logic signed [WIDTH-1:0] x1_r, y1_r;
  logic signed [WIDTH:0]   diff1_r;
  logic [ALPHA_W-1:0]      alpha1_r;

  logic                    v2_r, byp2_r;
  logic [CHW-1:0]          ch2_r;
  logic signed [WIDTH-1:0] x2_r, y2_r;
  logic signed [PW-1:0]    prod2_r;

  logic                    m_valid_r;
  logic [CHW-1:0]          m_ch_r;
  logic signed [WIDTH-1:0] m_data_r;

  logic                    hazard_s, ready_s, accept_s, ch_ok_s;
  logic signed [WIDTH-1:0] y_rd_s;
  logic signed [WIDTH:0]   diff_s;
  logic signed [PW-1:0]    diff_ext_s, alpha_ext_s, prod_s, rnd_s, shr_s;
  logic signed [SW-1:0]    inc_s, sum_s;
  logic signed [WIDTH-1:0] res_s;

  // Acceptance: stall while the same channel is still in S1 or S2 (its y_prev is stale)
  always_comb begin
    hazard_s = (v1_r && (ch1_r == bus.s_ch)) || (v2_r && (ch2_r == bus.s_ch));
    ready_s  = rst_n && en && !clr && !hazard_s;
    accept_s = ready_s && bus.s_valid;
    ch_ok_s  = (32'(bus.s_ch) < CH);
    if (ch_ok_s) y_rd_s = y_prev_r[bus.s_ch];
    else y_rd_s = {WIDTH{1'b0}};
    diff_s = {bus.s_data[WIDTH-1], bus.s_data} - {y_rd_s[WIDTH-1], y_rd_s};
  end

  // Datapath: exact product, round half up, saturating accumulate
  always_comb begin
    diff_ext_s  = PW'(diff1_r);
    alpha_ext_s = PW'(alpha1_r);
    prod_s      = diff_ext_s * alpha_ext_s;
    rnd_s       = prod2_r + RND_HALF;
    shr_s       = rnd_s >>> SCALE;
    inc_s       = SW'(shr_s);
    sum_s       = SW'(y2_r) + inc_s;
    if (byp2_r) res_s = x2_r;
    else res_s = sat_sum(sum_s);
  end

  // Alpha register, written independently of en and clr
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) alpha_r <= ALPHA_W'(ALPHA_RST);
    else if (alpha_we) alpha_r <= clamp_alpha(alpha_in);
    else alpha_r <= alpha_r;
  end

  // Pipeline and per-channel history; clr wins over en and acceptance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_r <= 1'b0; byp1_r <= 1'b0; ch1_r <= '0; x1_r <= '0; y1_r <= '0;
      diff1_r <= '0; alpha1_r <= '0;
      v2_r <= 1'b0; byp2_r <= 1'b0; ch2_r <= '0; x2_r <= '0; y2_r <= '0; prod2_r <= '0;
      m_valid_r <= 1'b0; m_ch_r <= '0; m_data_r <= '0;
      for (int c = 0; c < CH; c++) y_prev_r[c] <= '0;
    end else if (clr) begin
      v1_r <= 1'b0;
      v2_r <= 1'b0;
      m_valid_r <= 1'b0;
      for (int c = 0; c < CH; c++) y_prev_r[c] <= '0;
    end else if (!en) begin
      m_valid_r <= 1'b0;
    end else begin
      v1_r <= accept_s && ch_ok_s;
      if (accept_s) begin
        ch1_r    <= bus.s_ch;
        x1_r     <= bus.s_data;
        y1_r     <= y_rd_s;
        diff1_r  <= diff_s;
        byp1_r   <= bypass;
        alpha1_r <= alpha_r;
      end
      v2_r    <= v1_r;
      ch2_r   <= ch1_r;
      x2_r    <= x1_r;
      y2_r    <= y1_r;
      byp2_r  <= byp1_r;
      prod2_r <= prod_s;
      m_valid_r <= v2_r;
      if (v2_r) begin
        m_ch_r            <= ch2_r;
        m_data_r          <= res_s;
        y_prev_r[ch2_r]   <= res_s;
      end
    end
  end

  assign bus.s_ready = ready_s;
  assign bus.m_valid = m_valid_r;
  assign bus.m_ch    = m_ch_r;
  assign bus.m_data  = m_data_r;
endmodule

// File: tb/tb_lpf_iir_mc.sv
// Randomised and directed bench for lpf_iir_mc: a real-arithmetic filter model feeds
// an expectation queue that an independent monitor drains against the output strobe.
module tb_lpf_iir_mc;
  localparam int WIDTH = 10, SCALE = 15, ALPHA_W = 16, CH = 4, CHW = 2, ALPHA_RST = 12629;

  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, clr = 1'b0, bypass = 1'b0, alpha_we = 1'b0;
  logic [ALPHA_W-1:0] alpha_in = '0;

  lpf_iir_mc_if #(.WIDTH(WIDTH), .CHW(CHW)) bus ();

  lpf_iir_mc #(.WIDTH(WIDTH), .SCALE(SCALE), .ALPHA_W(ALPHA_W), .CH(CH), .CHW(CHW),
               .ALPHA_RST(ALPHA_RST)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .bypass(bypass),
    .alpha_we(alpha_we), .alpha_in(alpha_in), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct { int ch; int data; int due; } exp_t;
  exp_t exp_q[$];
  int   obs_q[$];
  int   recent[$];
  int   y_m[CH];
  int   alpha_m = ALPHA_RST;
  int   adv = 0;
  int   n_cmp = 0, n_err = 0;
  logic dut_ready;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // y + alpha*(x-y) with round half up, done as floor division on plain integers
  function automatic int model_filter(input int y, input int x, input int a);
    longint num, q;
    int r;
    num = longint'(x - y) * longint'(a) + 64'sd16384;
    q = num / 64'sd32768;
    if ((num % 64'sd32768) != 0 && num < 0) q = q - 1;
    r = y + int'(q);
    if (r > 511) r = 511;
    if (r < -512) r = -512;
    return r;
  endfunction

  function automatic bit busy(input int ch);
    foreach (recent[i]) if (recent[i] == ch) return 1'b1;
    return 1'b0;
  endfunction

  // One clock cycle: drive at posedge+1, predict at posedge+7 (after the monitor's negedge)
  task automatic tick(input logic v, input int ch, input int x, input logic byp,
                      input logic e, input logic c, input logic we, input int ain,
                      output logic acc);
    logic exp_ready;
    exp_t item;
    bus.s_valid = v; bus.s_ch = CHW'(ch); bus.s_data = WIDTH'(x);
    bypass = byp; en = e; clr = c; alpha_we = we; alpha_in = ALPHA_W'(ain);
    #6;
    exp_ready = rst_n && e && !c && !busy(ch);
    dut_ready = bus.s_ready;
    check("s_ready", int'(dut_ready), int'(exp_ready));
    acc = v && exp_ready;
    if (acc) begin
      y_m[ch] = byp ? x : model_filter(y_m[ch], x, alpha_m);
      item.ch = ch; item.data = y_m[ch]; item.due = adv + 3;
      exp_q.push_back(item);
    end
    if (we) alpha_m = (ain > 32768) ? 32768 : ain;
    if (c) begin
      exp_q.delete();
      recent.delete();
      foreach (y_m[i]) y_m[i] = 0;
    end else if (e) begin
      recent.push_back(acc ? ch : -1);
      if (recent.size() > 2) void'(recent.pop_front());
      adv++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    logic acc;
    tick(1'b0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 0, acc);
  endtask

  task automatic send(input int ch, input int x, input logic byp);
    logic acc;
    for (int k = 0; k < 8; k++) begin
      tick(1'b1, ch, x, byp, 1'b1, 1'b0, 1'b0, 0, acc);
      if (acc) return;
    end
    fail_now("send_timeout");
  endtask

  task automatic write_alpha(input int a);
    logic acc;
    tick(1'b0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b1, a, acc);
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && exp_q.size() > 0; k++) idle();
    idle();
    if (exp_q.size() > 0) fail_now("drain_timeout");
  endtask

  // Monitor: every strobe must match the oldest expectation, on the predicted cycle
  always @(negedge clk) begin
    exp_t e;
    if (bus.m_valid) begin
      if (exp_q.size() == 0) fail_now("unexpected_output");
      else begin
        e = exp_q.pop_front();
        check("m_ch", int'(bus.m_ch), e.ch);
        check("m_data", int'(bus.m_data), e.data);
        check("latency", adv, e.due);
      end
      obs_q.push_back(int'(bus.m_data));
    end else if (exp_q.size() > 0 && exp_q[0].due <= adv) begin
      fail_now("missing_output");
      void'(exp_q.pop_front());
    end
  end

  initial begin
    logic acc;
    bus.s_valid = 1'b0; bus.s_ch = '0; bus.s_data = '0;
    foreach (y_m[i]) y_m[i] = 0;
    en = 1'b1;
    #1;
    check("rst_m_valid", int'(bus.m_valid), 0);
    check("rst_m_ch", int'(bus.m_ch), 0);
    check("rst_m_data", int'(bus.m_data), 0);
    check("rst_s_ready", int'(bus.s_ready), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Step response on ch0
    obs_q.delete();
    for (int i = 0; i < 12; i++) send(0, 400, 1'b0);
    drain();
    check("step_count", obs_q.size(), 12);
    if (obs_q.size() >= 2) begin
      check("step_first", obs_q[0], 154);
      check("step_second", obs_q[1], 249);
      for (int i = 1; i < obs_q.size(); i++)
        check("step_monotonic", int'(obs_q[i] >= obs_q[i-1] && obs_q[i] <= 400), 1);
    end

    // Interleaved channels from a cleared state: full throughput
    tick(1'b0, 0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 0, acc);
    obs_q.delete();
    begin
      int xs[4] = '{400, 0, -400, 100};
      int ys[4] = '{154, 0, -154, 39};
      for (int c = 0; c < 4; c++) begin
        tick(1'b1, c, xs[c], 1'b0, 1'b1, 1'b0, 1'b0, 0, acc);
        check("interleave_ready", int'(dut_ready), 1);
      end
      drain();
      for (int c = 0; c < 4 && c < obs_q.size(); c++) check("interleave_data", obs_q[c], ys[c]);
    end

    // Same-channel hazard: ready pattern 1,0,0
    for (int i = 0; i < 6; i++) begin
      tick(1'b1, 0, 100, 1'b0, 1'b1, 1'b0, 1'b0, 0, acc);
      check("hazard_ready", int'(dut_ready), int'(i % 3 == 0));
    end
    drain();

    // Alpha clamp to unity, full swing, then alpha=0 holds
    write_alpha(40000);
    obs_q.delete();
    send(1, 511, 1'b0);
    send(1, -512, 1'b0);
    write_alpha(0);
    send(1, 100, 1'b0);
    drain();
    check("alpha_count", obs_q.size(), 3);
    if (obs_q.size() == 3) begin
      check("alpha_unity_pos", obs_q[0], 511);
      check("alpha_unity_neg", obs_q[1], -512);
      check("alpha_zero_hold", obs_q[2], -512);
    end
    write_alpha(ALPHA_RST);

    // Bypass then filtered with no transient
    obs_q.delete();
    send(2, 300, 1'b1);
    send(2, 300, 1'b0);
    drain();
    check("bypass_count", obs_q.size(), 2);
    if (obs_q.size() == 2) begin
      check("bypass_out", obs_q[0], 300);
      check("bypass_exit", obs_q[1], 300);
    end

    // en low freezes in-flight samples
    send(0, 250, 1'b0);
    send(3, -77, 1'b0);
    for (int i = 0; i < 5; i++) tick(1'b1, 1, 50, 1'b0, 1'b0, 1'b0, 1'b0, 0, acc);
    drain();

    // clr discards in-flight samples and zeroes history
    obs_q.delete();
    send(1, 200, 1'b0);
    send(2, -200, 1'b0);
    tick(1'b1, 3, 123, 1'b0, 1'b1, 1'b1, 1'b0, 0, acc);
    drain();
    check("clr_none_emitted", obs_q.size(), 0);
    send(0, 400, 1'b0);
    drain();
    if (obs_q.size() == 1) check("clr_restart", obs_q[0], 154);
    else check("clr_restart_count", obs_q.size(), 1);

    // Randomised traffic
    for (int i = 0; i < 1500; i++) begin
      logic v, byp, e, c, we;
      int ch, x, ain;
      v   = ($urandom_range(0, 3) != 0);
      ch  = int'($urandom_range(0, CH - 1));
      x   = int'($urandom_range(0, 1023)) - 512;
      byp = ($urandom_range(0, 9) == 0);
      e   = ($urandom_range(0, 19) != 0);
      c   = ($urandom_range(0, 59) == 0);
      we  = ($urandom_range(0, 29) == 0);
      ain = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 32768));
      tick(v, ch, x, byp, e, c, we, ain, acc);
    end
    drain();

    // Asynchronous reset mid-stream
    write_alpha(5000);
    send(0, 300, 1'b0);
    send(1, -300, 1'b0);
    send(2, 100, 1'b0);
    rst_n = 1'b0;
    bus.s_valid = 1'b0;
    #1;
    check("midrst_m_valid", int'(bus.m_valid), 0);
    check("midrst_m_ch", int'(bus.m_ch), 0);
    check("midrst_m_data", int'(bus.m_data), 0);
    check("midrst_s_ready", int'(bus.s_ready), 0);
    exp_q.delete();
    recent.delete();
    foreach (y_m[i]) y_m[i] = 0;
    alpha_m = ALPHA_RST;
    @(posedge clk); #1;
    rst_n = 1'b1;
    obs_q.delete();
    send(0, 400, 1'b0);
    drain();
    if (obs_q.size() == 1) check("midrst_alpha_reset", obs_q[0], 154);
    else check("midrst_count", obs_q.size(), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
